// File: rtl/rv_mul_ctrl.sv
// rv_mul_ctrl: RV64M multiply sequencer (issue, fixed-latency wait, sign fix-up, rsp handshake); MUL_FUSE_EN enables product reuse
module rv_mul_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req_vld_i,
  output logic         req_rdy_o,
  input  logic [1:0]   req_op_i,
  input  logic         req_word_i,
  input  logic [63:0]  req_rs1_i,
  input  logic [63:0]  req_rs2_i,
  input  logic [4:0]   req_rd_i,
  input  logic         flush_i,
  output logic         mul_start_o,
  output logic [63:0]  mul_op1_o,
  output logic [63:0]  mul_op2_o,
  input  logic [127:0] mul_prod_i,
  output logic         rsp_vld_o,
  input  logic         rsp_rdy_i,
  output logic [63:0]  rsp_data_o,
  output logic [4:0]   rsp_rd_o,
  output logic         busy_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [1:0] op_q;
  logic word_q;
  logic accept, fin, hit;
  logic [127:0] fuse_prod;
  function automatic logic [63:0] res_f(input logic [127:0] p, input logic [1:0] op, input logic word,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0] hi;
    hi = p[127:64] - ((a[63] && (op[1] ^ op[0])) ? b : 64'd0) - ((b[63] && op == 2'b01) ? a : 64'd0);
    return word ? {{32{p[31]}}, p[31:0]} : (op == 2'b00) ? p[63:0] : hi;
  endfunction
  assign accept = req_vld_i & req_rdy_o & ~flush_i;
  assign fin = (state == WAIT) && (cnt == 4'd0);
`ifdef MUL_FUSE_EN
  logic fuse_vld;
  logic [63:0] fuse_a, fuse_b;
  assign hit = accept & ~req_word_i & fuse_vld & (req_rs1_i == fuse_a) & (req_rs2_i == fuse_b);
  // reuse register: remember the last full-width product and its operand pair
  always_ff @(posedge clk)
    if (!rstn) begin
      fuse_vld <= 1'b0;
      fuse_prod <= '0;
      fuse_a <= '0;
      fuse_b <= '0;
    end else if (flush_i || (accept && req_word_i)) begin
      fuse_vld <= 1'b0;
    end else if (fin && !word_q) begin
      fuse_vld <= 1'b1;
      fuse_prod <= mul_prod_i;
      fuse_a <= mul_op1_o;
      fuse_b <= mul_op2_o;
    end
`else
  assign hit = 1'b0;
  assign fuse_prod = '0;
`endif
  // state register
  always_ff @(posedge clk)
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  // next state: flush overrides everything, a reuse hit skips straight to DONE
  always_comb begin
    state_nxt = flush_i ? IDLE :
                (state == IDLE)  ? (hit ? DONE : accept ? ISSUE : IDLE) :
                (state == ISSUE) ? WAIT :
                (state == WAIT)  ? (cnt == 4'd0 ? DONE : WAIT) :
                (rsp_rdy_i ? IDLE : DONE);
  end
  // state-decoded handshake and control outputs
  always_comb begin
    req_rdy_o = state == IDLE;
    mul_start_o = state == ISSUE;
    rsp_vld_o = state == DONE;
    busy_o = state != IDLE;
  end
  // request latch, latency counter and result register
  always_ff @(posedge clk)
    if (!rstn) begin
      cnt <= '0;
      op_q <= '0;
      word_q <= 1'b0;
      mul_op1_o <= '0;
      mul_op2_o <= '0;
      rsp_data_o <= '0;
      rsp_rd_o <= '0;
    end else begin
      if (accept) begin
        op_q <= req_op_i;
        word_q <= req_word_i;
        mul_op1_o <= req_rs1_i;
        mul_op2_o <= req_rs2_i;
        rsp_rd_o <= req_rd_i;
      end
      if (state == ISSUE) cnt <= 4'(MUL_LAT - 1);
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (hit) rsp_data_o <= res_f(fuse_prod, req_op_i, 1'b0, req_rs1_i, req_rs2_i);
      else if (fin && !flush_i) rsp_data_o <= res_f(mul_prod_i, op_q, word_q, mul_op1_o, mul_op2_o);
    end
endmodule

// File: tb/tb_rv_mul_ctrl.sv
// tb_rv_mul_ctrl: vector table + scoreboard bench for rv_mul_ctrl with a fixed-latency product model
module tb_rv_mul_ctrl;
  localparam int LAT = 3;
  localparam bit FUSE =
`ifdef MUL_FUSE_EN
    1'b1;
`else
    1'b0;
`endif
  localparam logic [127:0] JUNK = {4{32'hA5A5_5A5A}};
  logic clk = 1'b0, rstn = 1'b0, req_vld = 1'b0, req_word = 1'b0, flush = 1'b0, rsp_rdy = 1'b1;
  logic [1:0] req_op = '0;
  logic [63:0] req_rs1 = '0, req_rs2 = '0;
  logic [4:0] req_rd = '0;
  logic [127:0] mul_prod = JUNK;
  logic req_rdy, mul_start, rsp_vld, busy;
  logic [63:0] mul_op1, mul_op2, rsp_data;
  logic [4:0] rsp_rd;
  typedef struct { logic [1:0] op; logic word; logic [63:0] a; logic [63:0] b; logic [4:0] rd; logic [63:0] exp; } vec_t;
  typedef struct { logic [63:0] data; logic [4:0] rd; } rsp_t;
  vec_t tbl[12];
  rsp_t exp_q[$];
  int n_cmp = 0, n_err = 0, n_start = 0, k = 0, due = -1, acc_k = 0, rsp_k = 0;
  bit acc;
  logic [127:0] pp;
  logic [63:0] nx_data;
  logic [4:0] nx_rd;
  always #5 clk = ~clk;
  rv_mul_ctrl #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn), .req_vld_i(req_vld), .req_rdy_o(req_rdy), .req_op_i(req_op),
    .req_word_i(req_word), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_rd_i(req_rd),
    .flush_i(flush), .mul_start_o(mul_start), .mul_op1_o(mul_op1), .mul_op2_o(mul_op2),
    .mul_prod_i(mul_prod), .rsp_vld_o(rsp_vld), .rsp_rdy_i(rsp_rdy), .rsp_data_o(rsp_data),
    .rsp_rd_o(rsp_rd), .busy_o(busy)
  );
  function automatic logic [63:0] ref_f(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sb, ua, ub, p;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'd0, a};
    ub = {64'd0, b};
    p = w ? ua * ub : (op == 2'b01) ? sa * sb : (op == 2'b10) ? sa * ub : ua * ub;
    return w ? {{32{p[31]}}, p[31:0]} : (op == 2'b00) ? p[63:0] : p[127:64];
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    #1;
    if (mul_start) begin
      n_start++;
      pp = {64'd0, mul_op1} * {64'd0, mul_op2};
      due = k + LAT;
    end
    mul_prod = (k == due) ? pp : JUNK;
    if (rstn && req_vld && req_rdy && !flush) begin
      exp_q.push_back('{nx_data, nx_rd});
      acc = 1'b1;
      acc_k = k;
    end
    if (rstn && rsp_vld && rsp_rdy) begin
      rsp_k = k;
      if (exp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_vld), 64'd0);
      else begin
        chk("rsp_data", rsp_data, exp_q[0].data);
        chk("rsp_rd", 64'(rsp_rd), 64'(exp_q[0].rd));
        void'(exp_q.pop_front());
      end
    end
    k++;
    @(negedge clk);
  endtask
  task automatic set_req(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input logic [63:0] e);
    req_op = op;
    req_word = w;
    req_rs1 = a;
    req_rs2 = b;
    req_rd = rd;
    nx_data = e;
    nx_rd = rd;
  endtask
  task automatic do_req(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input logic [63:0] e);
    int t = 0;
    set_req(op, w, a, b, rd, e);
    acc = 1'b0;
    req_vld = 1'b1;
    while (!acc && t < 30) begin
      cyc();
      t++;
    end
    req_vld = 1'b0;
    if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
  endtask
  task automatic wait_rsp(input bit rnd);
    int t = 0;
    while (exp_q.size() > 0 && t < 80) begin
      rsp_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      t++;
    end
    rsp_rdy = 1'b1;
    if (exp_q.size() > 0) begin
      chk("rsp_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask
  initial begin
    int n0;
    logic [63:0] r1, r2;
    tbl[0] = '{2'b00, 1'b0, 64'd3, 64'd5, 5'd1, 64'd15};
    tbl[1] = '{2'b01, 1'b0, '1, '1, 5'd2, 64'd0};
    tbl[2] = '{2'b11, 1'b0, '1, '1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[3] = '{2'b10, 1'b0, '1, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[4] = '{2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[5] = '{2'b00, 1'b1, 64'h1_0000_0003, 64'd5, 5'd6, 64'hF};
    tbl[6] = '{2'b01, 1'b0, -64'sd7, 64'd9, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[7] = '{2'b00, 1'b0, -64'sd7, 64'd9, 5'd8, 64'hFFFF_FFFF_FFFF_FFC1};
    for (int i = 8; i < 12; i++) begin
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      tbl[i] = '{2'(i - 8), 1'b0, r1, r2, 5'(i + 12), ref_f(2'(i - 8), 1'b0, r1, r2)};
    end
    @(negedge clk);
    cyc();
    cyc();
    rstn = 1'b1;
    chk("rst_req_rdy", 64'(req_rdy), 64'd1);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(mul_start), 64'd0);
    chk("rst_data", rsp_data, 64'd0);
    chk("rst_op1", mul_op1, 64'd0);
    n0 = n_start;
    do_req(2'b00, 1'b0, 64'd3, 64'd5, 5'd1, 64'd15);
    wait_rsp(1'b0);
    chk("t1_starts", 64'(n_start - n0), 64'd1);
    chk("t1_latency", 64'(rsp_k - acc_k), 64'(LAT + 2));
    for (int i = 0; i < 12; i++) begin
      do_req(tbl[i].op, tbl[i].word, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp);
      wait_rsp(1'b1);
    end
    rsp_rdy = 1'b0;
    do_req(2'b11, 1'b0, '1, '1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE);
    for (int t = 0; t < 20 && !rsp_vld; t++) cyc();
    set_req(2'b00, 1'b0, 64'd6, 64'd7, 5'd6, 64'd42);
    acc = 1'b0;
    req_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_vld", 64'(rsp_vld), 64'd1);
      chk("bp_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("bp_rd", 64'(rsp_rd), 64'd5);
      chk("bp_req_rdy", 64'(req_rdy), 64'd0);
      cyc();
    end
    rsp_rdy = 1'b1;
    cyc();
    chk("bp_no_accept_in_done", 64'(acc), 64'd0);
    cyc();
    chk("bp_accept_after_hs", 64'(acc), 64'd1);
    chk("bp_accept_cycle", 64'(acc_k - rsp_k), 64'd1);
    req_vld = 1'b0;
    wait_rsp(1'b0);
    do_req(2'b00, 1'b0, 64'd100, 64'd7, 5'd2, 64'd700);
    cyc();
    cyc();
    chk("fl_busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    exp_q.delete();
    chk("fl_busy", 64'(busy), 64'd0);
    chk("fl_req_rdy", 64'(req_rdy), 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk("fl_no_rsp", 64'(rsp_vld), 64'd0);
      cyc();
    end
    n0 = n_start;
    set_req(2'b00, 1'b0, 64'd11, 64'd13, 5'd3, 64'd143);
    req_vld = 1'b1;
    flush = 1'b1;
    cyc();
    req_vld = 1'b0;
    flush = 1'b0;
    chk("fl_idle_busy", 64'(busy), 64'd0);
    cyc();
    cyc();
    chk("fl_idle_starts", 64'(n_start - n0), 64'd0);
    do_req(2'b00, 1'b0, 64'd11, 64'd13, 5'd3, 64'd143);
    wait_rsp(1'b0);
    do_req(2'b00, 1'b0, 64'h1234, 64'h55, 5'd9, 64'h1234 * 64'h55);
    cyc();
    cyc();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    exp_q.delete();
    chk("rw_data", rsp_data, 64'd0);
    chk("rw_op1", mul_op1, 64'd0);
    chk("rw_op2", mul_op2, 64'd0);
    chk("rw_rd", 64'(rsp_rd), 64'd0);
    chk("rw_busy", 64'(busy), 64'd0);
    chk("rw_req_rdy", 64'(req_rdy), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("rw_no_rsp", 64'(rsp_vld), 64'd0);
      cyc();
    end
    do_req(2'b01, 1'b0, -64'sd7, 64'd9, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_rsp(1'b0);
    n0 = n_start;
    do_req(2'b00, 1'b0, -64'sd7, 64'd9, 5'd4, 64'hFFFF_FFFF_FFFF_FFC1);
    wait_rsp(1'b0);
    chk("fuse_starts", 64'(n_start - n0), FUSE ? 64'd0 : 64'd1);
    chk("fuse_latency", 64'(rsp_k - acc_k), FUSE ? 64'd1 : 64'(LAT + 2));
    do_req(2'b00, 1'b1, -64'sd7, 64'd9, 5'd5, 64'hFFFF_FFFF_FFFF_FFC1);
    wait_rsp(1'b0);
    n0 = n_start;
    do_req(2'b00, 1'b0, -64'sd7, 64'd9, 5'd6, 64'hFFFF_FFFF_FFFF_FFC1);
    wait_rsp(1'b0);
    chk("mulw_clear_starts", 64'(n_start - n0), 64'd1);
    chk("mulw_clear_latency", 64'(rsp_k - acc_k), 64'(LAT + 2));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
